// File: rtl/uart_bus_ctrl_if.sv
// Peripheral-bus side of uart_bus_ctrl: register access strobes, read data and interrupt.
// The core drives the master modport; the controller implements the slave modport.
interface uart_bus_ctrl_if;
    logic [3:0]  addr;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (output addr, wr_en, rd_en, wdata, input rdata, irq);
    modport slave  (input addr, wr_en, rd_en, wdata, output rdata, irq);
endinterface

// File: rtl/uart_bus_ctrl.sv
// Host-side UART controller: TX/RX byte FIFOs, send-handshake FSM, and a
// control/status register block with a level interrupt on the peripheral bus.
module uart_bus_ctrl #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    uart_bus_ctrl_if.slave   bus,
    output logic             send,
    output logic [7:0]       data_in,
    output logic [1:0]       parity_type,
    output logic [1:0]       baud_rate,
    input  logic             tx_active_flag,
    input  logic             tx_done_flag,
    input  logic             rx_active_flag,
    input  logic             rx_done_flag,
    input  logic [7:0]       data_out,
    input  logic [2:0]       error_flag
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_ACT, WAIT_DONE} tx_state_e;
    typedef enum logic [1:0] {REG_TXDATA, REG_RXDATA, REG_STATUS, REG_CTRL} reg_sel_e;

    tx_state_e   state;
    reg_sel_e    sel;
    logic        unused_bits;

    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wr_ptr, tx_rd_ptr;
    logic [CW-1:0] tx_count;
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [AW-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [CW-1:0] rx_count;

    logic        tx_empty, tx_full, rx_empty, rx_full;
    logic        tx_push_req, tx_push, tx_pop;
    logic        rx_push_req, rx_push, rx_pop;
    logic        rx_done_prev, rx_edge;
    logic        tx_overflow, rx_overflow;
    logic [2:0]  err_sticky;
    logic        ie_rx, ie_tx;
    logic        status_wr, ctrl_wr;
    logic [31:0] status_clr;
    logic [31:0] read_mux;

    assign sel         = reg_sel_e'(bus.addr[3:2]);
    assign unused_bits = ^{bus.addr[1:0], bus.wdata[31:10]};

    // Full/empty come from the registered counts, i.e. the state at the start of the cycle.
    assign tx_empty = (tx_count == '0);
    assign tx_full  = (tx_count == FULL_CNT);
    assign rx_empty = (rx_count == '0);
    assign rx_full  = (rx_count == FULL_CNT);

    assign tx_push_req = bus.wr_en && (sel == REG_TXDATA);
    assign tx_push     = tx_push_req && !tx_full;
    assign tx_pop      = (state == IDLE) && !tx_empty && !tx_active_flag;

    assign rx_edge     = rx_done_flag && !rx_done_prev;
    assign rx_push_req = rx_edge && (error_flag == 3'b000);
    assign rx_push     = rx_push_req && !rx_full;
    assign rx_pop      = bus.rd_en && (sel == REG_RXDATA) && !rx_empty;

    assign status_wr  = bus.wr_en && (sel == REG_STATUS);
    assign ctrl_wr    = bus.wr_en && (sel == REG_CTRL);
    assign status_clr = status_wr ? bus.wdata : 32'h0;

    // NOTE: FIFO storage has no reset; the counts/pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= bus.wdata[7:0];
        if (rx_push) rx_mem[rx_wr_ptr] <= data_out;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
            tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
            rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
        end
    end

    // Sticky flags: a new event in the same cycle as a write-1-to-clear wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_done_prev <= 1'b0;
            tx_overflow  <= 1'b0;
            rx_overflow  <= 1'b0;
            err_sticky   <= 3'b000;
            ie_rx        <= 1'b0;
            ie_tx        <= 1'b0;
            parity_type  <= 2'b00;
            baud_rate    <= 2'b00;
        end else begin
            rx_done_prev <= rx_done_flag;
            tx_overflow  <= (tx_overflow & ~status_clr[5]) | (tx_push_req & tx_full);
            rx_overflow  <= (rx_overflow & ~status_clr[6]) | (rx_push_req & rx_full);
            err_sticky   <= (err_sticky & ~status_clr[9:7]) | (rx_edge ? error_flag : 3'b000);
            if (ctrl_wr) begin
                ie_rx <= bus.wdata[4];
                ie_tx <= bus.wdata[5];
                // Line settings must not change under a frame in either direction.
                if (state == IDLE && !rx_active_flag) begin
                    parity_type <= bus.wdata[1:0];
                    baud_rate   <= bus.wdata[3:2];
                end
            end
        end
    end

    // NOTE: default assignment first keeps this block purely combinational (no latch).
    always_comb begin
        read_mux = 32'h0;
        case (sel)
            REG_RXDATA: read_mux = rx_empty ? 32'h0 : {23'h0, 1'b1, rx_mem[rx_rd_ptr]};
            REG_STATUS: read_mux = {22'h0, err_sticky, rx_overflow, tx_overflow,
                                    (state != IDLE), rx_full, rx_empty, tx_full, tx_empty};
            REG_CTRL:   read_mux = {26'h0, ie_tx, ie_rx, baud_rate, parity_type};
            default:    read_mux = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.rdata <= 32'h0;
            bus.irq   <= 1'b0;
        end else begin
            if (bus.rd_en) bus.rdata <= read_mux;
            bus.irq <= (ie_rx & !rx_empty) | (ie_tx & tx_empty & (state == IDLE));
        end
    end

    // TX handshake: data_in is loaded only on a pop, so it stays put for the whole frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            send    <= 1'b0;
            data_in <= 8'h00;
        end else begin
            send <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_pop) begin
                        data_in <= tx_mem[tx_rd_ptr];
                        send    <= 1'b1;
                        state   <= LAUNCH;
                    end
                end
                LAUNCH: state <= WAIT_ACT;
                WAIT_ACT: begin
                    if (tx_done_flag)        state <= IDLE;
                    else if (tx_active_flag) state <= WAIT_DONE;
                end
                WAIT_DONE: if (tx_done_flag) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/uart_bus_ctrl.md
# uart_bus_ctrl

Memory-mapped host-side controller that sits between the RISC-V core's peripheral bus and the `uart` top. It acts as the initiator for the UART datapath. It buffers outgoing bytes in a TX FIFO and launches them with `send` handshakes. It captures received bytes and error flags on `rx_done_flag` into an RX FIFO, and exposes control, status and an interrupt to software.

## Interface

- `FIFO_DEPTH`, 4, entries per FIFO (power of two, ≥2)
- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `addr`  in  4  byte address; `addr[3:2]` selects register, `addr[1:0]` ignored
- `wr_en`  in  1  bus write strobe, one cycle per access
- `rd_en`  in  1  bus read strobe, one cycle per access
- `wdata`  in  32  write data
- `rdata`  out  32  read data, registered
- `irq`  out  1  level interrupt
- `send`  out  1  one-cycle pulse to UART transmitter
- `data_in`  out  8  byte to transmit, held stable until TX done
- `parity_type`  out  2  to UART
- `baud_rate`  out  2  to UART
- `tx_active_flag`, `tx_done_flag`  in  1 each  from UART transmitter
- `rx_active_flag`, `rx_done_flag`  in  1 each  from UART receiver
- `data_out`  in  8  received byte from UART
- `error_flag`  in  3  receiver error bits

## Operation

- Register map:
  - 0x0 TXDATA (W): push `wdata[7:0]` to the TX FIFO. Reads return 0.
  - 0x4 RXDATA (R): `{23'b0, valid, byte}`. If non-empty, returns the head with valid=1 and pops it. If empty, returns 0 and does not pop.
  - 0x8 STATUS: bit0 tx_empty, bit1 tx_full, bit2 rx_empty, bit3 rx_full, bit4 tx_busy (FSM≠IDLE), bit5 tx_overflow*, bit6 rx_overflow*, bits9:7 err_sticky*. Bits marked * are sticky and write-1-to-clear.
  - 0xC CTRL (RW): bits1:0 parity_type, bits3:2 baud_rate, bit4 ie_rx, bit5 ie_tx.
- CTRL bits3:0 are updated only when the TX FSM is IDLE and `rx_active_flag`=0. Otherwise those bits are ignored and bits5:4 are still written.
- Full and empty are evaluated on the count at the start of the cycle. A push while full is dropped and sets the overflow flag, even if a pop occurs in the same cycle. A push and pop in the same cycle on a non-full, non-empty FIFO leaves the count unchanged.
- TX FSM:
  - IDLE → LAUNCH when the TX FIFO is non-empty and `tx_active_flag`=0. In that cycle the head is popped into `data_in`.
  - LAUNCH: `send`=1 for exactly one cycle, then → WAIT_ACT.
  - WAIT_ACT → WAIT_DONE when `tx_active_flag`=1. It also goes directly → IDLE if `tx_done_flag`=1 is seen.
  - WAIT_DONE → IDLE when `tx_done_flag`=1.
- RX capture on the rising edge of `rx_done_flag` (registered previous value):
  - If `error_flag`=0, push `data_out` to the RX FIFO.
  - Otherwise OR `error_flag` into err_sticky and do not push.
  - A level held high counts as one event.
- `irq` = (ie_rx & !rx_empty) | (ie_tx & tx_empty & FSM==IDLE), registered.

## Timing

- Reset values: `send`=0, `data_in`=0, `parity_type`=0, `baud_rate`=0, `rdata`=0, `irq`=0. Both FIFOs are empty, all sticky bits are 0, the FSM is in IDLE, and the edge register is 0.
- Read latency is one cycle: `rdata` is valid the cycle after `rd_en`, and it holds its value until the next read.
- The RXDATA pop takes effect in the `rd_en` cycle.
- TX latency: a write to TXDATA into an empty FIFO with the FSM in IDLE gives the pop/`data_in` load on cycle +1 and `send`=1 on cycle +2.
- `data_in` changes only on a pop, so it is stable from LAUNCH through WAIT_DONE.
- RX latency: the byte is visible in the FIFO (rx_empty=0) one cycle after the `rx_done_flag` rising edge. `irq` asserts one cycle after that.
- Simultaneous `wr_en` and `rd_en`: both are performed.
- An asynchronous reset in any state forces the reset values immediately. Any in-flight UART frame is abandoned.

## Test plan

- Write TXDATA=0x55 in IDLE → `send` pulses once on cycle +2 with `data_in`=0x55. Model active for 10 cycles then done → FSM returns to IDLE and `tx_busy`=0.
- Write 6 bytes 0x01..0x06 with the UART stalled, `FIFO_DEPTH`=4 → 0x01 is in flight and 0x02..0x05 are queued. The push of 0x06 is dropped and tx_overflow=1. Four more `send` pulses then follow in order, each after the previous done.
- Pulse `rx_done_flag` with `data_out`=0xA3, `error_flag`=0 → read RXDATA returns 0x1A3. The next read returns 0x000.
- `rx_done_flag` held high for 3 cycles with `error_flag`=3'b010 → no push, err_sticky=3'b010. Write STATUS with bit8 set → err_sticky=0.
- Write CTRL=0x3B while `rx_active_flag`=1 → parity/baud stay 0 and ie_tx=1, ie_rx=1. Repeat with the UART idle → parity_type=3, baud_rate=2.
- Assert `reset` low during WAIT_DONE with 2 bytes queued → `send`=0, `data_in`=0, STATUS shows both FIFOs empty, and no `send` pulse occurs after release.
